// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared types and helpers for the 5-stage 16-bit pipeline hazard sequencer.
//   - FSM state encoding (RUN / MEM_WAIT / ERROR)
//   - register-address and datapath widths
//   - ctrl_t: bundle of pipeline-register enables and NOP injects
//   - helper functions that build the control bundle for each situation
// No ports (package).
// ---------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int DATA_W     = 16;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    // Bit order matches the bench's packed observation vector.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_bubble;
    } ctrl_t;

    // Free-running pipeline: every register loads, nothing is squashed.
    localparam ctrl_t CTRL_DEFAULT = ctrl_t'(8'b1111_1000);
    // Data memory busy: everything up to EX/MEM holds, a bubble drains into WB.
    localparam ctrl_t CTRL_FREEZE  = ctrl_t'(8'b0000_1001);
    // Timed-out memory: whole pipe stopped, WB keeps seeing NOPs.
    localparam ctrl_t CTRL_ERROR   = ctrl_t'(8'b0000_0001);

    // Source operand collides with the register a load is producing.
    function automatic logic reg_hit(input logic                  uses,
                                     input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] dest);
        return uses & (src == dest);
    endfunction

    // Control when the memory stage is not stalling: branch beats load-use,
    // because a taken branch squashes the dependent instruction anyway.
    function automatic ctrl_t ctrl_run(input logic branch_taken,
                                       input logic load_use);
        ctrl_t c;
        c = CTRL_DEFAULT;
        if (branch_taken) begin
            c.if_id_flush = 1'b1;
            c.id_ex_flush = 1'b1;
        end else if (load_use) begin
            c.pc_en       = 1'b0;
            c.if_id_en    = 1'b0;
            c.id_ex_flush = 1'b1;
        end else begin
            c = CTRL_DEFAULT;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_hazard_detect
// Combinational load-use detector: flags when the instruction in ID reads a
// register that the load currently in EX will write. r0 is hard-wired zero
// and never creates a dependency.
// Ports:
//   id_src1, id_src2        in  ID-stage source register addresses
//   id_uses_src1/2          in  ID instruction actually reads that source
//   ex_mem_read             in  EX instruction is a load
//   ex_dest                 in  EX destination register
//   load_use                out stall required this cycle
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_uses_src1,
    input  logic                  id_uses_src2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    output logic                  load_use
);

    // Compare both ID sources against the load destination.
    always_comb begin
        load_use = 1'b0;
        if (ex_mem_read && (ex_dest != {REG_ADDR_W{1'b0}})) begin
            load_use = reg_hit(id_uses_src1, id_src1, ex_dest) |
                       reg_hit(id_uses_src2, id_src2, ex_dest);
        end else begin
            load_use = 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush sequencer for the 5-stage pipeline. Resolves load-use hazards,
// taken-branch flushes and variable-latency data-memory waits, and drives the
// per-register load enables and NOP injects. Enables/flushes are
// combinational from state and inputs; wait counter, stall counter and the
// sticky timeout flag are registered.
// Parameters:
//   MEM_TIMEOUT  consecutive MEM_WAIT cycles tolerated before ERROR (>=1)
//   CNT_W        width of stall_count
// Ports:
//   clock, reset                  clock; synchronous active-high reset
//   id_src1/2, id_uses_src1/2     ID-stage operand info
//   ex_mem_read, ex_dest          EX-stage load info
//   ex_branch_taken               EX branch resolved taken
//   mem_req, mem_ready            MEM-stage access handshake
//   pc_en .. mem_wb_en            pipeline register load enables
//   if_id_flush, id_ex_flush      load NOP into IF/ID, ID/EX
//   mem_wb_bubble                 load NOP into MEM/WB
//   mem_error                     sticky memory-timeout flag
//   stall_count                   saturating count of cycles with pc_en=0
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_uses_src1,
    input  logic                  id_uses_src2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_wb_bubble,
    output logic                  mem_error,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

    state_e              state_r;
    state_e              state_s;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_s;
    logic                set_err_s;
    logic                mem_error_r;
    logic [CNT_W-1:0]    stall_count_r;
    logic                load_use_s;
    ctrl_t               ctrl_s;

    pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_uses_src1 (id_uses_src1),
        .id_uses_src2 (id_uses_src2),
        .ex_mem_read  (ex_mem_read),
        .ex_dest      (ex_dest),
        .load_use     (load_use_s)
    );

    // Next-state, wait-count and pipeline control decode.
    always_comb begin
        ctrl_s     = CTRL_DEFAULT;
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        set_err_s  = 1'b0;
        if (reset) begin
            // Reset wins over any hazard: pipe runs freely while it is held.
            ctrl_s     = CTRL_DEFAULT;
            state_s    = ST_RUN;
            wait_cnt_s = {WAIT_W{1'b0}};
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (mem_req && !mem_ready) begin
                        ctrl_s     = CTRL_FREEZE;
                        state_s    = ST_MEM_WAIT;
                        wait_cnt_s = WAIT_W'(1);
                    end else begin
                        ctrl_s = ctrl_run(ex_branch_taken, load_use_s);
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        // Upstream was frozen, so branch/load-use seen now are
                        // the ones deferred from the stall: apply them once.
                        ctrl_s     = ctrl_run(ex_branch_taken, load_use_s);
                        state_s    = ST_RUN;
                        wait_cnt_s = {WAIT_W{1'b0}};
                    end else begin
                        ctrl_s = CTRL_FREEZE;
                        if (wait_cnt_r == WAIT_W'(MEM_TIMEOUT)) begin
                            state_s   = ST_ERROR;
                            set_err_s = 1'b1;
                        end else begin
                            wait_cnt_s = wait_cnt_r + WAIT_W'(1);
                        end
                    end
                end
                ST_ERROR: begin
                    ctrl_s = CTRL_ERROR;
                end
                default: begin
                    // Illegal encoding: stop the pipe and recover to RUN.
                    ctrl_s     = CTRL_ERROR;
                    state_s    = ST_RUN;
                    wait_cnt_s = {WAIT_W{1'b0}};
                end
            endcase
        end
    end

    // State, wait counter, sticky error flag and saturating stall counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_RUN;
            wait_cnt_r    <= {WAIT_W{1'b0}};
            mem_error_r   <= 1'b0;
            stall_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            wait_cnt_r  <= wait_cnt_s;
            mem_error_r <= mem_error_r | set_err_s;
            if (!ctrl_s.pc_en && (stall_count_r != STALL_MAX)) begin
                stall_count_r <= stall_count_r + CNT_W'(1);
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    assign pc_en         = ctrl_s.pc_en;
    assign if_id_en      = ctrl_s.if_id_en;
    assign id_ex_en      = ctrl_s.id_ex_en;
    assign ex_mem_en     = ctrl_s.ex_mem_en;
    assign mem_wb_en     = ctrl_s.mem_wb_en;
    assign if_id_flush   = ctrl_s.if_id_flush;
    assign id_ex_flush   = ctrl_s.id_ex_flush;
    assign mem_wb_bubble = ctrl_s.mem_wb_bubble;
    assign mem_error     = mem_error_r;
    assign stall_count   = stall_count_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl. Control outputs are observed as
// one 8-bit vector {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id_flush,
// id_ex_flush, mem_wb_bubble}. stall_count is 4 bits so saturation is
// reachable in the timeout scenario.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam logic [7:0] C_RUN    = 8'hF8;
    localparam logic [7:0] C_FREEZE = 8'h09;
    localparam logic [7:0] C_LU     = 8'h3A;
    localparam logic [7:0] C_BR     = 8'hFE;
    localparam logic [7:0] C_ERR    = 8'h01;

    logic       clock;
    logic       reset;
    logic [2:0] id_src1, id_src2, ex_dest;
    logic       id_uses_src1, id_uses_src2, ex_mem_read, ex_branch_taken;
    logic       mem_req, mem_ready;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, mem_wb_bubble, mem_error;
    logic [3:0] stall_count;
    logic [7:0] ctrl_obs;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .id_src1         (id_src1),
        .id_src2         (id_src2),
        .id_uses_src1    (id_uses_src1),
        .id_uses_src2    (id_uses_src2),
        .ex_mem_read     (ex_mem_read),
        .ex_dest         (ex_dest),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_bubble   (mem_wb_bubble),
        .mem_error       (mem_error),
        .stall_count     (stall_count)
    );

    assign ctrl_obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_flush, mem_wb_bubble};

    // Free-running clock, 10-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, leaving margin before the falling edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_hazards();
        id_src1 = 3'd0; id_src2 = 3'd0; ex_dest = 3'd0;
        id_uses_src1 = 1'b0; id_uses_src2 = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_hazards();
        mem_req = 1'b1; mem_ready = 1'b0;       // hazard request ignored under reset
        #2;
        chk("reset_ctrl", 32'(ctrl_obs), 32'(C_RUN));
        tick();
        tick();
        chk("reset_stall", 32'(stall_count), 32'd0);
        chk("reset_err", 32'(mem_error), 32'd0);
        reset = 1'b0; mem_req = 1'b0;
        #1;
        chk("idle_ctrl", 32'(ctrl_obs), 32'(C_RUN));

        // Load-use on src1
        ex_mem_read = 1'b1; ex_dest = 3'd3; id_src1 = 3'd3; id_uses_src1 = 1'b1;
        #1;
        chk("lu_src1", 32'(ctrl_obs), 32'(C_LU));
        tick();
        chk("lu_src1_cnt", 32'(stall_count), 32'd1);
        clear_hazards();
        #1;
        chk("lu_cleared", 32'(ctrl_obs), 32'(C_RUN));

        // Load-use on src2; then same regs without the use bit
        ex_mem_read = 1'b1; ex_dest = 3'd5; id_src2 = 3'd5; id_uses_src2 = 1'b1;
        id_src1 = 3'd5;                          // src1 matches but unused
        #1;
        chk("lu_src2", 32'(ctrl_obs), 32'(C_LU));
        tick();
        chk("lu_src2_cnt", 32'(stall_count), 32'd2);
        id_uses_src2 = 1'b0;
        #1;
        chk("no_use_bits", 32'(ctrl_obs), 32'(C_RUN));

        // Load to r0 never stalls
        clear_hazards();
        ex_mem_read = 1'b1; ex_dest = 3'd0; id_src1 = 3'd0; id_uses_src1 = 1'b1;
        #1;
        chk("r0_no_stall", 32'(ctrl_obs), 32'(C_RUN));
        tick();
        chk("r0_cnt", 32'(stall_count), 32'd2);

        // Branch beats load-use
        ex_dest = 3'd3; id_src1 = 3'd3; ex_branch_taken = 1'b1;
        #1;
        chk("br_over_lu", 32'(ctrl_obs), 32'(C_BR));
        tick();
        chk("br_cnt", 32'(stall_count), 32'd2);
        clear_hazards();

        // Zero-wait memory access
        mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        chk("zero_wait", 32'(ctrl_obs), 32'(C_RUN));
        tick();
        chk("zero_wait_cnt", 32'(stall_count), 32'd2);

        // Three freeze cycles then release
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mw_freeze%0d", i), 32'(ctrl_obs), 32'(C_FREEZE));
            tick();
        end
        chk("mw_cnt", 32'(stall_count), 32'd5);
        mem_ready = 1'b1;
        #1;
        chk("mw_release", 32'(ctrl_obs), 32'(C_RUN));
        tick();
        chk("mw_release_cnt", 32'(stall_count), 32'd5);
        mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        chk("mw_back_run", 32'(ctrl_obs), 32'(C_RUN));

        // Branch deferred across a memory wait
        mem_req = 1'b1; ex_branch_taken = 1'b1;
        #1;
        chk("defer_br_freeze", 32'(ctrl_obs), 32'(C_FREEZE));
        tick();
        mem_ready = 1'b1;
        #1;
        chk("defer_br_release", 32'(ctrl_obs), 32'(C_BR));
        tick();
        chk("defer_br_cnt", 32'(stall_count), 32'd6);
        clear_hazards(); mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        chk("defer_br_after", 32'(ctrl_obs), 32'(C_RUN));

        // Load-use deferred across a memory wait
        mem_req = 1'b1;
        ex_mem_read = 1'b1; ex_dest = 3'd6; id_src2 = 3'd6; id_uses_src2 = 1'b1;
        #1;
        chk("defer_lu_freeze", 32'(ctrl_obs), 32'(C_FREEZE));
        tick();
        mem_ready = 1'b1;
        #1;
        chk("defer_lu_release", 32'(ctrl_obs), 32'(C_LU));
        tick();
        chk("defer_lu_cnt", 32'(stall_count), 32'd8);
        clear_hazards(); mem_req = 1'b0; mem_ready = 1'b0;

        // Timeout: entry cycle plus 15 MEM_WAIT cycles, then ERROR
        mem_req = 1'b1;
        #1;
        chk("to_entry", 32'(ctrl_obs), 32'(C_FREEZE));
        tick();
        for (int i = 1; i <= 15; i++) begin
            #1;
            chk($sformatf("to_wait%0d", i), 32'(ctrl_obs), 32'(C_FREEZE));
            chk($sformatf("to_err_low%0d", i), 32'(mem_error), 32'd0);
            tick();
        end
        chk("to_error_ctrl", 32'(ctrl_obs), 32'(C_ERR));
        chk("to_error_flag", 32'(mem_error), 32'd1);
        chk("to_stall_sat", 32'(stall_count), 32'd15);
        mem_req = 1'b0; mem_ready = 1'b1;
        tick();
        tick();
        chk("err_hold_ctrl", 32'(ctrl_obs), 32'(C_ERR));
        chk("err_hold_flag", 32'(mem_error), 32'd1);
        chk("err_hold_sat", 32'(stall_count), 32'd15);

        // Reset out of ERROR
        reset = 1'b1;
        #1;
        chk("err_reset_ctrl", 32'(ctrl_obs), 32'(C_RUN));
        tick();
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        chk("err_reset_run", 32'(ctrl_obs), 32'(C_RUN));
        chk("err_reset_flag", 32'(mem_error), 32'd0);
        chk("err_reset_cnt", 32'(stall_count), 32'd0);

        // Reset in the middle of a memory wait
        mem_req = 1'b1;
        tick();
        tick();
        chk("mid_wait_cnt", 32'(stall_count), 32'd2);
        reset = 1'b1;
        #1;
        chk("mid_reset_ctrl", 32'(ctrl_obs), 32'(C_RUN));
        tick();
        reset = 1'b0; mem_req = 1'b0;
        #1;
        chk("mid_reset_run", 32'(ctrl_obs), 32'(C_RUN));
        chk("mid_reset_cnt", 32'(stall_count), 32'd0);
        chk("mid_reset_err", 32'(mem_error), 32'd0);
        tick();
        chk("mid_reset_hold", 32'(stall_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
